// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2,
    FLUSH  = 2'd3
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned LOAD_LAT_MIN = 1;
  localparam int unsigned LOAD_LAT_MAX = 4;

  // Remaining-stall counter only ever holds LOAD_LAT-1 or less.
  localparam int unsigned STALL_CNT_W = $clog2(LOAD_LAT_MAX);

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID-stage hazard inputs, stage-register controls, perf counters.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ifIdRs;
  logic [4:0]       ifIdRt;
  logic             ifIdUsesRt;
  logic             idExMemRead;
  logic [4:0]       idExRt;
  logic             branchTaken;
  logic             memBusy;

  logic             pcWrite;
  logic             ifIdWrite;
  logic             ifIdFlush;
  logic             idExBubble;
  logic             exMemFlush;
  logic             freeze;
  logic [1:0]       state;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushEvents;
  logic [CNT_W-1:0] freezeCycles;

  modport master (
    output ifIdRs, ifIdRt, ifIdUsesRt, idExMemRead, idExRt, branchTaken, memBusy,
    input  pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemFlush, freeze, state,
    input  stallCycles, flushEvents, freezeCycles
  );

  modport slave (
    input  ifIdRs, ifIdRt, ifIdUsesRt, idExMemRead, idExRt, branchTaken, memBusy,
    output pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemFlush, freeze, state,
    output stallCycles, flushEvents, freezeCycles
  );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a pending load writes a register the ID instruction reads.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] src_rs,
  input  logic [4:0] src_rt,
  input  logic       src_uses_rt,
  input  logic       dst_valid,
  input  logic [4:0] dst_reg,
  output logic       hit
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (dst_reg == src_rs);
    rt_match = src_uses_rt && (dst_reg == src_rt);
    hit      = dst_valid && (dst_reg != REG_ZERO) && (rs_match || rt_match);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// MIPS 5-stage hazard controller: load-use stalls, branch flush, memory freeze.
// Define HAZARD_PERF_CNT_EN to build the saturating performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clock,
  input  logic           resetN,
  hazard_ctrl_if.slave   hz_if
);

  localparam int unsigned LAT = (LOAD_LAT < LOAD_LAT_MIN) ? LOAD_LAT_MIN :
                                (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX : LOAD_LAT;
  localparam logic [STALL_CNT_W-1:0] STALL_LOAD = STALL_CNT_W'(LAT - 1);

  hz_state_e              state_q, state_d;
  hz_state_e              ret_state_q, ret_state_d;
  hz_state_e              eff_state;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic hz;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, freeze;

  load_use_detect u_load_use_detect (
    .src_rs      (hz_if.ifIdRs),
    .src_rt      (hz_if.ifIdRt),
    .src_uses_rt (hz_if.ifIdUsesRt),
    .dst_valid   (hz_if.idExMemRead),
    .dst_reg     (hz_if.idExRt),
    .hit         (hz)
  );

  always_comb begin
    // Leaving FREEZE resumes the saved state's behaviour in the same cycle.
    eff_state    = (state_q == FREEZE) ? ret_state_q : state_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;
    freeze       = 1'b0;
    state_d      = state_q;
    ret_state_d  = ret_state_q;
    cnt_d        = cnt_q;

    if (hz_if.memBusy) begin
      freeze      = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ret_state_d = eff_state;
      state_d     = FREEZE;
    end else if (hz_if.branchTaken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
      cnt_d        = '0;
      state_d      = FLUSH;
    end else begin
      unique case (eff_state)
        STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_d        = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
          state_d      = (cnt_q <= STALL_CNT_W'(1)) ? RUN : STALL;
        end
        // IF/ID holds the squashed NOP, so no hazard can be real here.
        FLUSH: state_d = RUN;
        default: begin
          state_d = RUN;
          if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LAT > 1) begin
              cnt_d   = STALL_LOAD;
              state_d = STALL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= RUN;
      ret_state_q <= RUN;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      cnt_q       <= cnt_d;
    end
  end

  // Reset forces a safe hold on every stage register without waiting for a clock.
  always_comb begin
    hz_if.pcWrite    = resetN & pc_write;
    hz_if.ifIdWrite  = resetN & if_id_write;
    hz_if.ifIdFlush  = resetN & if_id_flush;
    hz_if.idExBubble = ~resetN | id_ex_bubble;
    hz_if.exMemFlush = resetN & ex_mem_flush;
    hz_if.freeze     = ~resetN | freeze;
    hz_if.state      = state_q;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] flush_evt_q, flush_evt_d;
  logic [CNT_W-1:0] freeze_cyc_q, freeze_cyc_d;

  always_comb begin
    stall_cyc_d  = stall_cyc_q;
    flush_evt_d  = flush_evt_q;
    freeze_cyc_d = freeze_cyc_q;
    if (id_ex_bubble && !hz_if.branchTaken && (stall_cyc_q != '1))
      stall_cyc_d = stall_cyc_q + CNT_W'(1);
    if (hz_if.branchTaken && (flush_evt_q != '1))
      flush_evt_d = flush_evt_q + CNT_W'(1);
    if (freeze && (freeze_cyc_q != '1))
      freeze_cyc_d = freeze_cyc_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stall_cyc_q  <= '0;
      flush_evt_q  <= '0;
      freeze_cyc_q <= '0;
    end else begin
      stall_cyc_q  <= stall_cyc_d;
      flush_evt_q  <= flush_evt_d;
      freeze_cyc_q <= freeze_cyc_d;
    end
  end

  always_comb begin
    hz_if.stallCycles  = stall_cyc_q;
    hz_if.flushEvents  = flush_evt_q;
    hz_if.freezeCycles = freeze_cyc_q;
  end
`else
  always_comb begin
    hz_if.stallCycles  = '0;
    hz_if.flushEvents  = '0;
    hz_if.freezeCycles = '0;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with LOAD_LAT = 1, 2 and 3 instances sharing stimulus.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  logic       clock  = 1'b0;
  logic       resetN = 1'b0;
  logic [4:0] rs = '0, rt = '0, exrt = '0;
  logic       uses = 1'b0, mr = 1'b0, br = 1'b0, busy = 1'b0;

  // ctl = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemFlush, freeze, state[1:0]}
  logic [7:0]       ctl [3];
  logic [CNT_W-1:0] pst [3];
  logic [CNT_W-1:0] pfl [3];
  logic [CNT_W-1:0] pfz [3];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.LOAD_LAT(g + 1), .CNT_W(CNT_W)) dut (
      .clock  (clock),
      .resetN (resetN),
      .hz_if  (bus.slave)
    );

    assign bus.ifIdRs      = rs;
    assign bus.ifIdRt      = rt;
    assign bus.ifIdUsesRt  = uses;
    assign bus.idExMemRead = mr;
    assign bus.idExRt      = exrt;
    assign bus.branchTaken = br;
    assign bus.memBusy     = busy;

    assign ctl[g] = {bus.pcWrite, bus.ifIdWrite, bus.ifIdFlush, bus.idExBubble,
                     bus.exMemFlush, bus.freeze, bus.state};
    assign pst[g] = bus.stallCycles;
    assign pfl[g] = bus.flushEvents;
    assign pfz[g] = bus.freezeCycles;
  end

  typedef struct {
    int         sel;
    logic       rstn;
    logic       mr;
    logic [4:0] exrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       br;
    logic       busy;
    logic [7:0] exp;
    logic       chk;
    int         ps;
    int         pf;
    int         pz;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input int sel, input logic rstn, input logic m, input logic [4:0] er,
                     input logic [4:0] s, input logic [4:0] t, input logic u,
                     input logic b, input logic bz, input logic [7:0] e);
    vec_t v;
    v.sel = sel; v.rstn = rstn; v.mr = m; v.exrt = er; v.rs = s; v.rt = t;
    v.uses = u; v.br = b; v.busy = bz; v.exp = e; v.chk = 1'b0;
    v.ps = 0; v.pf = 0; v.pz = 0;
    tbl.push_back(v);
  endtask

  task automatic perf(input int s, input int f, input int z);
    tbl[tbl.size()-1].chk = 1'b1;
    tbl[tbl.size()-1].ps  = s;
    tbl[tbl.size()-1].pf  = f;
    tbl[tbl.size()-1].pz  = z;
  endtask

  function automatic int pe(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial begin
    vec_t t;

    // sel, rstn, mr, exrt, rs, rt, uses, br, busy, expected ctl
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h14);   // reset values
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC0);
    // load-use on rs, LOAD_LAT=2
    add(1, 1, 1, 5, 5, 0, 0, 0, 0, 8'h10);
    add(1, 1, 1, 5, 5, 0, 0, 0, 0, 8'h11);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC0);  perf(pe(2), 0, 0);
    // register zero never stalls, rt gated by use, LOAD_LAT=1
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h14);
    add(0, 1, 1, 0, 0, 0, 1, 0, 0, 8'hC0);
    add(0, 1, 1, 7, 3, 7, 0, 0, 0, 8'hC0);
    add(0, 1, 1, 7, 3, 7, 1, 0, 0, 8'h10);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC0);  perf(pe(1), 0, 0);
    // branch in the 2nd STALL cycle, LOAD_LAT=3
    add(2, 0, 0, 0, 0, 0, 0, 0, 0, 8'h14);
    add(2, 1, 1, 5, 5, 0, 0, 0, 0, 8'h10);
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 8'h11);
    add(2, 1, 0, 0, 0, 0, 0, 1, 0, 8'hF9);
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC3);
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC0);  perf(pe(2), pe(1), 0);
    // freeze for 4 cycles inside a LOAD_LAT=3 stall
    add(2, 0, 0, 0, 0, 0, 0, 0, 0, 8'h14);
    add(2, 1, 1, 5, 5, 0, 0, 0, 0, 8'h10);
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 8'h11);
    add(2, 1, 0, 0, 0, 0, 0, 0, 1, 8'h05);
    add(2, 1, 0, 0, 0, 0, 0, 0, 1, 8'h06);
    add(2, 1, 0, 0, 0, 0, 0, 0, 1, 8'h06);
    add(2, 1, 0, 0, 0, 0, 0, 0, 1, 8'h06);
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 8'h12);
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC0);  perf(pe(3), 0, pe(4));
    // memBusy while in FLUSH resumes FLUSH, LOAD_LAT=2
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h14);
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 8'hF8);
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h07);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC2);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC0);  perf(0, pe(1), pe(1));
    // hazard together with branch: branch wins
    add(1, 1, 1, 5, 5, 0, 0, 1, 0, 8'hF8);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC3);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC0);
    // LOAD_LAT=1 single bubble, then freeze from RUN resuming into a hazard
    add(0, 1, 1, 9, 9, 0, 0, 0, 0, 8'h10);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h04);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h06);
    add(0, 1, 1, 9, 9, 0, 0, 0, 0, 8'h12);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'hC0);

    @(posedge clock); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      resetN = t.rstn; mr = t.mr; exrt = t.exrt; rs = t.rs; rt = t.rt;
      uses = t.uses; br = t.br; busy = t.busy;
      #2;
      check($sformatf("vec%0d_ctl", i), 32'(ctl[t.sel]), 32'(t.exp));
      if (t.chk) begin
        check($sformatf("vec%0d_stallCycles", i),  32'(pst[t.sel]), 32'(t.ps));
        check($sformatf("vec%0d_flushEvents", i),  32'(pfl[t.sel]), 32'(t.pf));
        check($sformatf("vec%0d_freezeCycles", i), 32'(pfz[t.sel]), 32'(t.pz));
      end
      @(posedge clock); #1;
    end

    // Asynchronous reset in the middle of a LOAD_LAT=3 stall
    resetN = 1'b1; mr = 1'b1; exrt = 5'd4; rs = 5'd4; rt = '0; uses = 1'b0; br = 1'b0; busy = 1'b0;
    @(posedge clock); #1;
    mr = 1'b0; exrt = '0; rs = '0;
    #2;
    check("async_pre_stall", 32'(ctl[2]), 32'h11);
    resetN = 1'b0;
    #1;
    check("async_rst_ctl", 32'(ctl[2]), 32'h14);
    check("async_rst_cnt", 32'(pst[2]) + 32'(pfl[2]) + 32'(pfz[2]), 32'd0);
    @(posedge clock); #1;
    resetN = 1'b1;
    #2;
    check("async_release", 32'(ctl[2]), 32'hC0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
